// File: rtl/vga_vram_arbiter.sv
// Character-RAM arbiter for the 80x30 text display: fetch > writer > clear, fixed 3-clk fetch latency.
// Optional writer stall counter output enabled by defining VGA_ARB_STALL_CNT_EN.
module vga_vram_arbiter #(
    parameter int                ADDR_W     = 12,
    parameter int                DATA_W     = 8,
    parameter int                DEPTH      = 2400,
    parameter logic [DATA_W-1:0] CLEAR_CHAR = 8'h20
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
`ifdef VGA_ARB_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ZERO_A  = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] ZERO_D  = {DATA_W{1'b0}};

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clear_cnt_q, clear_cnt_d;
    logic                clear_busy_q, clear_busy_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic                ram_we_q, ram_we_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic                wr_ack_q, wr_ack_d;
    logic                f_vld1_q, f_vld1_d, f_oor1_q, f_oor1_d;
    logic                f_vld2_q, f_vld2_d, f_oor2_q, f_oor2_d;
    logic                fetch_valid_q, fetch_valid_d;
    logic [DATA_W-1:0]   fetch_data_q, fetch_data_d;

    logic                fetch_oor_s, wr_oor_s, wr_grant_s, clr_grant_s;

    // wr_ack_q doubles as the writer mask so a held wr_req is not granted twice
    assign fetch_oor_s = (fetch_addr >= DEPTH_A);
    assign wr_oor_s    = (wr_addr >= DEPTH_A);
    assign wr_grant_s  = wr_req & ~fetch_req & ~wr_ack_q;
    assign clr_grant_s = (state_q == ST_CLEAR) & ~fetch_req & ~wr_grant_s;

    // RAM bus next-value from the winning requester; out-of-range accesses leave the bus idle
    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        wr_ack_d    = 1'b0;
        if (fetch_req) begin
            if (!fetch_oor_s) begin
                ram_addr_d = fetch_addr;
            end else begin
                ram_addr_d = ram_addr_q;
            end
        end else if (wr_grant_s) begin
            wr_ack_d = 1'b1;
            if (!wr_oor_s) begin
                ram_addr_d  = wr_addr;
                ram_wdata_d = wr_data;
                ram_we_d    = 1'b1;
            end else begin
                ram_we_d = 1'b0;
            end
        end else if (clr_grant_s) begin
            ram_addr_d  = clear_cnt_q;
            ram_wdata_d = CLEAR_CHAR;
            ram_we_d    = 1'b1;
        end else begin
            ram_we_d = 1'b0;
        end
    end

    // Clear engine state and fill pointer
    always_comb begin
        state_d     = state_q;
        clear_cnt_d = clear_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_start) begin
                    state_d     = ST_CLEAR;
                    clear_cnt_d = ZERO_A;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (clr_grant_s) begin
                    if (clear_cnt_q == LAST_A) begin
                        state_d     = ST_IDLE;
                        clear_cnt_d = ZERO_A;
                    end else begin
                        clear_cnt_d = clear_cnt_q + ONE_A;
                    end
                end else begin
                    clear_cnt_d = clear_cnt_q;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                clear_cnt_d = ZERO_A;
            end
        endcase
        clear_busy_d = (state_d == ST_CLEAR);
    end

    // Fetch pipeline: request -> address on bus -> RAM data -> registered result
    always_comb begin
        f_vld1_d      = fetch_req;
        f_oor1_d      = fetch_req & fetch_oor_s;
        f_vld2_d      = f_vld1_q;
        f_oor2_d      = f_oor1_q;
        fetch_valid_d = f_vld2_q;
        fetch_data_d  = fetch_data_q;
        if (f_vld2_q) begin
            if (f_oor2_q) begin
                fetch_data_d = CLEAR_CHAR;
            end else begin
                fetch_data_d = ram_rdata;
            end
        end else begin
            fetch_data_d = fetch_data_q;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            clear_cnt_q   <= ZERO_A;
            clear_busy_q  <= 1'b0;
            ram_addr_q    <= ZERO_A;
            ram_we_q      <= 1'b0;
            ram_wdata_q   <= ZERO_D;
            wr_ack_q      <= 1'b0;
            f_vld1_q      <= 1'b0;
            f_oor1_q      <= 1'b0;
            f_vld2_q      <= 1'b0;
            f_oor2_q      <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_data_q  <= ZERO_D;
        end else begin
            state_q       <= state_d;
            clear_cnt_q   <= clear_cnt_d;
            clear_busy_q  <= clear_busy_d;
            ram_addr_q    <= ram_addr_d;
            ram_we_q      <= ram_we_d;
            ram_wdata_q   <= ram_wdata_d;
            wr_ack_q      <= wr_ack_d;
            f_vld1_q      <= f_vld1_d;
            f_oor1_q      <= f_oor1_d;
            f_vld2_q      <= f_vld2_d;
            f_oor2_q      <= f_oor2_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_data_q  <= fetch_data_d;
        end
    end

    assign fetch_data  = fetch_data_q;
    assign fetch_valid = fetch_valid_q;
    assign wr_ack      = wr_ack_q;
    assign clear_busy  = clear_busy_q;
    assign ram_addr    = ram_addr_q;
    assign ram_we      = ram_we_q;
    assign ram_wdata   = ram_wdata_q;

`ifdef VGA_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles an unmasked writer loses to a fetch
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (clear_start) begin
            stall_cnt_d = 16'h0000;
        end else if (wr_req && !wr_ack_q && fetch_req && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'h0001;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Self-checking bench for vga_vram_arbiter with a behavioural RAM and shadow-memory reference model.
module tb_vga_vram_arbiter;
    localparam int         ADDR_W = 12;
    localparam int         DATA_W = 8;
    localparam int         DEPTH  = 2400;
    localparam logic [7:0] CLR    = 8'h20;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              fetch_req = 1'b0;
    logic [ADDR_W-1:0] fetch_addr = 12'h000;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_valid;
    logic              wr_req = 1'b0;
    logic [ADDR_W-1:0] wr_addr = 12'h000;
    logic [DATA_W-1:0] wr_data = 8'h00;
    logic              wr_ack;
    logic              clear_start = 1'b0;
    logic              clear_busy;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
`ifdef VGA_ARB_STALL_CNT_EN
    logic [15:0]       stall_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct { int due; logic [7:0] data; } fexp_t;
    fexp_t fq[$];

    logic [7:0]  mem    [0:4095];
    logic [7:0]  shadow [0:4095];
    logic        pl_en = 1'b0;
    logic        pl_fill = 1'b0;
    logic [11:0] pl_addr = 12'h000;
    logic [7:0]  pl_data = 8'h00;

    vga_vram_arbiter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_data (fetch_data),
        .fetch_valid(fetch_valid),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .clear_start(clear_start),
        .clear_busy (clear_busy),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
`ifdef VGA_ARB_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM with a bench-side preload port
    always @(posedge clk) begin
        if (pl_fill) begin
            for (int i = 0; i < 4096; i++) mem[i] <= pl_data;
        end else if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [11:0] a, input logic [7:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        next_cycle();
        pl_en   = 1'b0;
    endtask

    task automatic fill(input logic [7:0] d);
        pl_data = d;
        pl_fill = 1'b1;
        next_cycle();
        pl_fill = 1'b0;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        fetch_req   = 1'b0;
        wr_req      = 1'b0;
        clear_start = 1'b0;
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        n_checks++;
        if ({fetch_valid, wr_ack, clear_busy, ram_we} !== 4'b0000) $display("FAIL reset_ctl: got %b expected 0000", {fetch_valid, wr_ack, clear_busy, ram_we});
        else n_pass++;
        n_checks++;
        if (ram_addr !== 12'h000) $display("FAIL reset_ram_addr: got %0h expected 0", ram_addr);
        else n_pass++;
        n_checks++;
        if ({ram_wdata, fetch_data} !== 16'h0000) $display("FAIL reset_data: got %0h expected 0", {ram_wdata, fetch_data});
        else n_pass++;
`ifdef VGA_ARB_STALL_CNT_EN
        n_checks++;
        if (stall_cnt !== 16'h0000) $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
        else n_pass++;
`endif
        next_cycle();
        reset_n = 1'b1;
    endtask

    task automatic test_fetch_basic();
        logic       exp_v;
        logic [7:0] exp_d;
        preload(12'd0, 8'h41);
        preload(12'd1, 8'h42);
        preload(12'd2, 8'h43);
        for (int k = 0; k < 8; k++) begin
            fetch_req  = (k < 3);
            fetch_addr = (k < 3) ? 12'(k) : 12'd0;
            @(negedge clk);
            exp_v = (k >= 3) && (k < 6);
            n_checks++;
            if (fetch_valid !== exp_v) $display("FAIL fetch_basic_valid[%0d]: got %b expected %b", k, fetch_valid, exp_v);
            else n_pass++;
            if (exp_v) begin
                exp_d = 8'h41 + 8'(k - 3);
                n_checks++;
                if (fetch_data !== exp_d) $display("FAIL fetch_basic_data[%0d]: got %0h expected %0h", k, fetch_data, exp_d);
                else n_pass++;
            end
            next_cycle();
        end
        fetch_req = 1'b0;
    endtask

    task automatic test_write();
        int  we_cnt = 0;
        logic got_ack = 1'b0;
        wr_req  = 1'b1;
        wr_addr = 12'd5;
        wr_data = 8'h37;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_checks++;
            if (wr_ack !== (k == 1)) $display("FAIL write_ack[%0d]: got %b expected %b", k, wr_ack, (k == 1));
            else n_pass++;
            if (ram_we) we_cnt++;
            if (k == 1) begin
                n_checks++;
                if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 12'd5, 8'h37})
                    $display("FAIL write_bus: got we=%b addr=%0h data=%0h expected we=1 addr=5 data=37", ram_we, ram_addr, ram_wdata);
                else n_pass++;
            end
            if (wr_ack) got_ack = 1'b1;
            next_cycle();
            if (got_ack) wr_req = 1'b0;
        end
        n_checks++;
        if (we_cnt != 1) $display("FAIL write_count: got %0d expected 1", we_cnt);
        else n_pass++;
        for (int k = 0; k < 5; k++) begin
            fetch_req  = (k == 0);
            fetch_addr = 12'd5;
            @(negedge clk);
            n_checks++;
            if (fetch_valid !== (k == 3)) $display("FAIL write_readback_valid[%0d]: got %b expected %b", k, fetch_valid, (k == 3));
            else n_pass++;
            if (k == 3) begin
                n_checks++;
                if (fetch_data !== 8'h37) $display("FAIL write_readback_data: got %0h expected 37", fetch_data);
                else n_pass++;
            end
            next_cycle();
        end
        fetch_req = 1'b0;
    endtask

    task automatic test_collision();
        logic got_ack = 1'b0;
        do_reset();
        preload(12'd9, 8'h99);
        for (int k = 0; k < 5; k++) begin
            fetch_req  = (k == 0);
            fetch_addr = 12'd9;
            if (k == 0) begin
                wr_req  = 1'b1;
                wr_addr = 12'd6;
                wr_data = 8'h66;
            end
            @(negedge clk);
            case (k)
                1: begin
                    n_checks++;
                    if ({wr_ack, ram_we, ram_addr} !== {1'b0, 1'b0, 12'd9})
                        $display("FAIL collision_fetch_bus: got ack=%b we=%b addr=%0h expected ack=0 we=0 addr=9", wr_ack, ram_we, ram_addr);
                    else n_pass++;
                end
                2: begin
                    n_checks++;
                    if ({wr_ack, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 12'd6, 8'h66})
                        $display("FAIL collision_write_bus: got ack=%b we=%b addr=%0h data=%0h expected ack=1 we=1 addr=6 data=66", wr_ack, ram_we, ram_addr, ram_wdata);
                    else n_pass++;
`ifdef VGA_ARB_STALL_CNT_EN
                    n_checks++;
                    if (stall_cnt !== 16'd1) $display("FAIL collision_stall_cnt: got %0d expected 1", stall_cnt);
                    else n_pass++;
`endif
                end
                3: begin
                    n_checks++;
                    if ({fetch_valid, fetch_data, wr_ack} !== {1'b1, 8'h99, 1'b0})
                        $display("FAIL collision_fetch_result: got valid=%b data=%0h ack=%b expected valid=1 data=99 ack=0", fetch_valid, fetch_data, wr_ack);
                    else n_pass++;
                end
                default: begin
                    n_checks++;
                    if (wr_ack !== 1'b0) $display("FAIL collision_ack[%0d]: got %b expected 0", k, wr_ack);
                    else n_pass++;
                end
            endcase
            if (wr_ack) got_ack = 1'b1;
            next_cycle();
            if (got_ack) wr_req = 1'b0;
        end
    endtask

    task automatic test_clear();
        int busy_cnt = 0, first_busy = -1, last_busy = -1, last_we = -1;
        int next_a = 0, seq_err = 0;
        for (int c = 0; c < 2600; c++) begin
            clear_start = (c == 0) || (c == 100);
            @(negedge clk);
            if (clear_busy) begin
                busy_cnt++;
                if (first_busy < 0) first_busy = c;
                last_busy = c;
            end
            if (ram_we) begin
                if ((ram_addr !== 12'(next_a)) || (ram_wdata !== CLR)) seq_err++;
                next_a++;
                last_we = c;
            end
            next_cycle();
        end
        clear_start = 1'b0;
        n_checks++;
        if (busy_cnt != 2400) $display("FAIL clear_busy_len: got %0d expected 2400", busy_cnt);
        else n_pass++;
        n_checks++;
        if (first_busy != 1) $display("FAIL clear_busy_start: got %0d expected 1", first_busy);
        else n_pass++;
        n_checks++;
        if (next_a != 2400) $display("FAIL clear_write_count: got %0d expected 2400", next_a);
        else n_pass++;
        n_checks++;
        if (seq_err != 0) $display("FAIL clear_write_seq: got %0d bad writes expected 0", seq_err);
        else n_pass++;
        n_checks++;
        if (last_we != last_busy + 1) $display("FAIL clear_busy_fall: last write cycle %0d expected %0d", last_we, last_busy + 1);
        else n_pass++;
    endtask

    task automatic test_clear_fetch();
        int g = 0, busy_err = 0, lat_err = 0, data_err = 0, issued = 0, seen = 0, bad_mem = 0;
        logic [11:0] a;
        logic [7:0]  e;
        logic        exp_busy, exp_v;
        fill(8'h55);
        fq.delete();
        for (int c = 0; c < 2820; c++) begin
            clear_start = (c == 0);
            fetch_req   = (c >= 3) && (((c - 3) % 8) == 0) && (c < 2800);
            a           = 12'($urandom_range(0, DEPTH - 1));
            fetch_addr  = a;
            exp_busy    = (c >= 1) && (g < DEPTH);
            if (fetch_req) begin
                e = (int'(a) < g) ? CLR : 8'h55;
                fq.push_back('{c + 3, e});
                issued++;
            end
            @(negedge clk);
            if (clear_busy !== exp_busy) busy_err++;
            exp_v = (fq.size() > 0) && (fq[0].due == c);
            if (fetch_valid !== exp_v) lat_err++;
            if (exp_v) begin
                if (fetch_valid && (fetch_data !== fq[0].data)) data_err++;
                if (fetch_valid) seen++;
                void'(fq.pop_front());
            end
            if (exp_busy && !fetch_req) g++;
            next_cycle();
        end
        clear_start = 1'b0;
        fetch_req   = 1'b0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== CLR) bad_mem++;
        n_checks++;
        if (busy_err != 0) $display("FAIL clrf_busy: got %0d mismatching cycles expected 0", busy_err);
        else n_pass++;
        n_checks++;
        if (lat_err != 0) $display("FAIL clrf_latency: got %0d mismatching cycles expected 0", lat_err);
        else n_pass++;
        n_checks++;
        if (data_err != 0) $display("FAIL clrf_data: got %0d bad fetches expected 0", data_err);
        else n_pass++;
        n_checks++;
        if (seen != issued) $display("FAIL clrf_count: got %0d fetch results expected %0d", seen, issued);
        else n_pass++;
        n_checks++;
        if (bad_mem != 0) $display("FAIL clrf_mem: got %0d uncleared cells expected 0", bad_mem);
        else n_pass++;
    endtask

    task automatic test_oor_reset();
        logic got_ack = 1'b0;
        int   post = 0;
        preload(12'd17, 8'h71);
        preload(12'd2400, 8'hAA);
        preload(12'd4095, 8'h00);
        for (int k = 0; k < 6; k++) begin
            fetch_req  = (k < 2);
            fetch_addr = (k == 0) ? 12'd17 : 12'd2400;
            @(negedge clk);
            case (k)
                2: begin
                    n_checks++;
                    if ({ram_we, ram_addr} !== {1'b0, 12'd17}) $display("FAIL oor_fetch_bus: got we=%b addr=%0h expected we=0 addr=11", ram_we, ram_addr);
                    else n_pass++;
                end
                3: begin
                    n_checks++;
                    if ({fetch_valid, fetch_data} !== {1'b1, 8'h71}) $display("FAIL oor_prev_fetch: got valid=%b data=%0h expected 1/71", fetch_valid, fetch_data);
                    else n_pass++;
                end
                4: begin
                    n_checks++;
                    if ({fetch_valid, fetch_data} !== {1'b1, CLR}) $display("FAIL oor_fetch_data: got valid=%b data=%0h expected 1/20", fetch_valid, fetch_data);
                    else n_pass++;
                end
                default: begin
                end
            endcase
            next_cycle();
        end
        fetch_req = 1'b0;
        wr_req  = 1'b1;
        wr_addr = 12'd4095;
        wr_data = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                n_checks++;
                if ({wr_ack, ram_we} !== 2'b10) $display("FAIL oor_write: got ack=%b we=%b expected ack=1 we=0", wr_ack, ram_we);
                else n_pass++;
            end
            if (wr_ack) got_ack = 1'b1;
            next_cycle();
            if (got_ack) wr_req = 1'b0;
        end
        n_checks++;
        if (mem[4095] !== 8'h00) $display("FAIL oor_write_mem: got %0h expected 0", mem[4095]);
        else n_pass++;
        for (int c = 0; c < 61; c++) begin
            clear_start = (c == 0);
            fetch_req   = (c == 60);
            fetch_addr  = 12'd3;
            next_cycle();
        end
        clear_start = 1'b0;
        fetch_req   = 1'b0;
        wr_req      = 1'b1;
        wr_addr     = 12'd8;
        wr_data     = 8'h5A;
        n_checks++;
        if (clear_busy !== 1'b1) $display("FAIL reset_mid_busy: got %b expected 1", clear_busy);
        else n_pass++;
        #1;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({fetch_valid, fetch_data, wr_ack, clear_busy, ram_addr, ram_we, ram_wdata} !== 32'h0)
            $display("FAIL reset_mid_outputs: got %0h expected 0", {fetch_valid, fetch_data, wr_ack, clear_busy, ram_addr, ram_we, ram_wdata});
        else n_pass++;
        next_cycle();
        next_cycle();
        wr_req  = 1'b0;
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (fetch_valid || clear_busy || ram_we || wr_ack) post++;
            next_cycle();
        end
        n_checks++;
        if (post != 0) $display("FAIL reset_mid_after: got %0d active cycles expected 0", post);
        else n_pass++;
    endtask

    task automatic test_random();
        logic        pend = 1'b0;
        int          waitc = 0, lat_err = 0, we_err = 0;
        logic [11:0] a;
        logic [7:0]  e;
        logic        exp_v;
        for (int i = 0; i < 4096; i++) shadow[i] = mem[i];
        fq.delete();
        for (int c = 0; c < 1500; c++) begin
            if (!pend) wr_req = 1'b0;
            if (!pend && (c < 1480) && ($urandom_range(0, 2) == 0)) begin
                pend    = 1'b1;
                waitc   = 0;
                wr_addr = ($urandom_range(0, 9) == 0) ? 12'($urandom_range(DEPTH, 4095)) : 12'($urandom_range(0, DEPTH - 1));
                wr_data = 8'($urandom_range(0, 255));
                wr_req  = 1'b1;
            end
            fetch_req  = (c < 1490) && ($urandom_range(0, 3) == 0);
            a          = 12'($urandom_range(0, 2599));
            fetch_addr = a;
            @(negedge clk);
            if (wr_ack) begin
                n_checks++;
                if (!pend) begin
                    $display("FAIL rand_spurious_ack: cycle %0d got ack expected none", c);
                end else if (wr_addr < 12'(DEPTH)) begin
                    if ({ram_we, ram_addr, ram_wdata} !== {1'b1, wr_addr, wr_data})
                        $display("FAIL rand_write_bus: got we=%b addr=%0h data=%0h expected we=1 addr=%0h data=%0h", ram_we, ram_addr, ram_wdata, wr_addr, wr_data);
                    else n_pass++;
                    shadow[wr_addr] = wr_data;
                end else begin
                    if (ram_we !== 1'b0) $display("FAIL rand_oor_write: got we=%b expected 0", ram_we);
                    else n_pass++;
                end
                pend = 1'b0;
            end else begin
                if (ram_we) we_err++;
                if (pend) begin
                    waitc++;
                    if (waitc > 16) begin
                        n_checks++;
                        $display("FAIL rand_ack_timeout: waited %0d cycles expected ack", waitc);
                        pend = 1'b0;
                    end
                end
            end
            if (fetch_req) begin
                e = (a >= 12'(DEPTH)) ? CLR : shadow[a];
                fq.push_back('{c + 3, e});
            end
            exp_v = (fq.size() > 0) && (fq[0].due == c);
            if (fetch_valid !== exp_v) lat_err++;
            if (exp_v) begin
                if (fetch_valid) begin
                    n_checks++;
                    if (fetch_data !== fq[0].data) $display("FAIL rand_fetch_data: cycle %0d got %0h expected %0h", c, fetch_data, fq[0].data);
                    else n_pass++;
                end
                void'(fq.pop_front());
            end
            next_cycle();
        end
        wr_req    = 1'b0;
        fetch_req = 1'b0;
        n_checks++;
        if (lat_err != 0) $display("FAIL rand_latency: got %0d mismatching cycles expected 0", lat_err);
        else n_pass++;
        n_checks++;
        if (we_err != 0) $display("FAIL rand_stray_write: got %0d stray writes expected 0", we_err);
        else n_pass++;
        n_checks++;
        if (fq.size() != 0) $display("FAIL rand_drain: got %0d outstanding fetches expected 0", fq.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fetch_basic();
        test_write();
        test_collision();
        test_clear();
        test_clear_fetch();
        test_oor_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
